// File: rtl/divider_stream.sv
// Iterative radix-2 restoring divider with valid/ready on both sides.
// Ports: clk, rst (async active-low); in_valid/in_ready/sgn/x/y in;
//        busy, out_valid/out_ready, q/r quotient+remainder, dbz/ovf flags.
module divider_stream #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] rem, dvd, dvs;
  logic [CW-1:0]    cnt;
  logic             negq, negr;
  logic             edbz, eovf;

  logic             s_in;
  logic [WIDTH-1:0] minv;
  logic [WIDTH-1:0] xa, ya;
  logic             is_dbz, is_ovf, is_exc;
  logic             acc, last;
  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] qm, rm;

  assign s_in   = SIGNED_EN && sgn;
  assign minv   = {1'b1, {(WIDTH-1){1'b0}}};
  assign is_dbz = (y == '0);
  assign is_ovf = s_in && (x == minv) && (&y);
  assign is_exc = is_dbz || is_ovf;

  // MIN magnitude still fits as an unsigned WIDTH-bit value.
  assign xa = (s_in && x[WIDTH-1]) ? -x : x;
  assign ya = (s_in && y[WIDTH-1]) ? -y : y;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign acc  = in_valid && in_ready;
  assign last = (cnt == CW'(1));

  assign sh   = {rem, dvd[WIDTH-1]};
  assign ge   = (sh >= {1'b0, dvs});
  assign diff = sh - {1'b0, dvs};
  assign rm   = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign qm   = {dvd[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == IDLE): if (in_valid)  state_d = CALC;
      (state == CALC): if (last)      state_d = DONE;
      (state == DONE): if (out_ready) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Exceptions spend a single CALC cycle (cnt=1) so their result
  // is written on the edge after accept, like the last normal step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem  <= '0;
      dvd  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      negq <= 1'b0;
      negr <= 1'b0;
      edbz <= 1'b0;
      eovf <= 1'b0;
      q    <= '0;
      r    <= '0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else if (acc) begin
      rem  <= '0;
      dvd  <= is_exc ? x : xa;
      dvs  <= ya;
      cnt  <= is_exc ? CW'(1) : CW'(WIDTH);
      negq <= s_in && (x[WIDTH-1] ^ y[WIDTH-1]);
      negr <= s_in && x[WIDTH-1];
      edbz <= is_dbz;
      eovf <= is_ovf;
    end else if (state == CALC) begin
      rem <= rm;
      dvd <= qm;
      cnt <= cnt - CW'(1);
      if (last) begin
        unique case (1'b1)
          edbz: begin
            q   <= '1;
            r   <= dvd;
            dbz <= 1'b1;
            ovf <= 1'b0;
          end
          eovf: begin
            q   <= dvd;
            r   <= '0;
            dbz <= 1'b0;
            ovf <= 1'b1;
          end
          default: begin
            q   <= negq ? -qm : qm;
            r   <= negr ? -rm : rm;
            dbz <= 1'b0;
            ovf <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_stream.sv
// Scoreboard bench for divider_stream at WIDTH=6.
// Directed vectors; a monitor pops expectations on each handshake.
module tb_divider_stream;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         sgn = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         in_ready, busy, out_valid, dbz, ovf;
  logic [W-1:0] q, r;

  int pass  = 0;
  int total = 0;

  logic [2*W+1:0] sb[$];

  always #5 clk = ~clk;

  divider_stream #(
    .WIDTH    (W),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sgn      (sgn),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .r        (r),
    .dbz      (dbz),
    .ovf      (ovf)
  );

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  always @(negedge clk) begin : mon
    logic [2*W+1:0] e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("stale_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("q", int'(q), int'(e[2*W+1:W+2]));
        chk("r", int'(r), int'(e[W+1:2]));
        chk("dbz", int'(dbz), int'(e[1]));
        chk("ovf", int'(ovf), int'(e[0]));
      end
    end
  end

  task automatic issue(input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic ed,
                       input logic eo, input bit push);
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    sgn = s;
    x = a;
    y = b;
    in_valid = 1'b1;
    if (push) sb.push_back({eq, er, ed, eo});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
    sgn = 1'($urandom);
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_result(input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("released", int'(out_valid), 0);
  endtask

  task automatic op(input logic s, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] eq,
                    input logic [W-1:0] er, input logic ed,
                    input logic eo, input int lat);
    issue(s, a, b, eq, er, ed, eo, 1'b1);
    wait_result(lat);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_dbz", int'(dbz), 0);
    chk("rst_ovf", int'(ovf), 0);
    #10 rst = 1'b1;

    op(1'b0, 6'd11, 6'd3,  6'd3,  6'd2,  1'b0, 1'b0, 6);
    op(1'b1, 6'd57, 6'd2,  6'd61, 6'd63, 1'b0, 1'b0, 6);
    op(1'b1, 6'd7,  6'd62, 6'd61, 6'd1,  1'b0, 1'b0, 6);
    op(1'b0, 6'd10, 6'd0,  6'd63, 6'd10, 1'b1, 1'b0, 1);
    op(1'b1, 6'd10, 6'd0,  6'd63, 6'd10, 1'b1, 1'b0, 1);
    op(1'b1, 6'd32, 6'd63, 6'd32, 6'd0,  1'b0, 1'b1, 1);
    op(1'b0, 6'd32, 6'd63, 6'd0,  6'd32, 1'b0, 1'b0, 6);
    op(1'b0, 6'd63, 6'd1,  6'd63, 6'd0,  1'b0, 1'b0, 6);
    op(1'b1, 6'd32, 6'd2,  6'd48, 6'd0,  1'b0, 1'b0, 6);
    op(1'b1, 6'd63, 6'd32, 6'd0,  6'd63, 1'b0, 1'b0, 6);
    op(1'b1, 6'd62, 6'd63, 6'd2,  6'd0,  1'b0, 1'b0, 6);
    op(1'b0, 6'd57, 6'd2,  6'd28, 6'd1,  1'b0, 1'b0, 6);
    op(1'b0, 6'd5,  6'd7,  6'd0,  6'd5,  1'b0, 1'b0, 6);

    // backpressure
    @(negedge clk);
    out_ready = 1'b0;
    issue(1'b0, 6'd11, 6'd3, 6'd3, 6'd2, 1'b0, 1'b0, 1'b1);
    wait_result(6);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      sgn = 1'b0;
      x = 6'd1;
      y = 6'd1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_q", int'(q), 3);
      chk("bp_r", int'(r), 2);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_still_done", int'(out_valid), 1);
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", int'(in_ready), 1);
    chk("bp_out_valid_after", int'(out_valid), 0);
    op(1'b1, 6'd57, 6'd2, 6'd61, 6'd63, 1'b0, 1'b0, 6);

    // abort mid-calculation
    issue(1'b0, 6'd11, 6'd3, 6'd3, 6'd2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_q", int'(q), 0);
    chk("abort_r", int'(r), 0);
    chk("abort_dbz", int'(dbz), 0);
    chk("abort_ovf", int'(ovf), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    op(1'b0, 6'd11, 6'd3, 6'd3, 6'd2, 1'b0, 1'b0, 6);

    repeat (2) @(posedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
